dlsc_rvh_fifo: RTL and testbench

DLSC_RVH_FIFO -- requirements
Module: dlsc_rvh_fifo

---
 rtl/dlsc_rvh_fifo.sv | 76 +++++++
 tb/tb_dlsc_rvh_fifo.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/dlsc_rvh_fifo.sv
// Ready/valid FIFO with first-word-fall-through output and registered status.
// in_ready, out_valid, count and almost_full all come straight from flops.
module dlsc_rvh_fifo #(
  parameter int              DATA        = 32,
  parameter int              DEPTH       = 4,
  parameter logic [DATA-1:0] RESET       = {DATA{1'b0}},
  parameter int              ALMOST_FULL = DEPTH-1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  output logic                   in_ready,
  input  logic                   in_valid,
  input  logic [DATA-1:0]        in_data,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [DATA-1:0]        out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   almost_full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA-1:0] r_mem [DEPTH];
  logic [AW-1:0]   r_wptr, r_rptr;
  logic [CW-1:0]   r_count, w_count_nxt;
  logic            r_in_ready, r_out_valid, r_almost_full;
  logic            w_push, w_pop;

  assign w_push = in_valid  & r_in_ready;
  assign w_pop  = out_ready & r_out_valid;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push & ~w_pop)      w_count_nxt = r_count + CW'(1);
    else if (~w_push & w_pop) w_count_nxt = r_count - CW'(1);
  end

  // Status flags are computed from the next count so they stay pure registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_in_ready    <= 1'b0;
      r_out_valid   <= 1'b0;
      r_almost_full <= 1'b0;
    end else if (flush) begin
      r_rptr        <= r_wptr;
      r_count       <= '0;
      r_in_ready    <= 1'b1;
      r_out_valid   <= 1'b0;
      r_almost_full <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      r_count       <= w_count_nxt;
      r_in_ready    <= (w_count_nxt < CW'(DEPTH));
      r_out_valid   <= (w_count_nxt != '0);
      r_almost_full <= (w_count_nxt >= CW'(ALMOST_FULL));
    end
  end

  // Storage is not reset; validity is tracked by the count alone.
  always_ff @(posedge clk) begin
    if (w_push && !flush) r_mem[r_wptr] <= in_data;
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign count       = r_count;
  assign almost_full = r_almost_full;
  assign out_data    = r_out_valid ? r_mem[r_rptr] : RESET;

endmodule

// File: tb/tb_dlsc_rvh_fifo.sv
// Bench for dlsc_rvh_fifo: a DEPTH=4 instance driven by directed scenarios and
// a DEPTH=8 instance driven randomly, both checked every cycle against a queue model.
module tb_dlsc_rvh_fifo;

  logic       clk = 1'b0;
  logic       rst  [2];
  logic       fl   [2];
  logic       iv   [2];
  logic       ordy [2];
  logic [7:0] id   [2];
  int         msz  [2];

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_f
    localparam int DP = (g == 0) ? 4 : 8;

    logic                ir, ov, af;
    logic [7:0]          od;
    logic [$clog2(DP):0] cnt;

    dlsc_rvh_fifo #(.DATA(8), .DEPTH(DP)) u_dut (
      .clk(clk), .rst(rst[g]), .flush(fl[g]),
      .in_ready(ir), .in_valid(iv[g]), .in_data(id[g]),
      .out_ready(ordy[g]), .out_valid(ov), .out_data(od),
      .count(cnt), .almost_full(af)
    );

    // Reference model: a queue of stored words plus a "just reset" flag that
    // holds in_ready low until the first clock edge after reset.
    logic [7:0] q[$];
    bit         blk = 1'b1;

    always @(posedge clk or posedge rst[g]) begin
      if (rst[g]) begin
        q.delete();
        blk = 1'b1;
      end else begin
        bit pu, po;
        pu = iv[g] && !blk && (q.size() < DP);
        po = ordy[g] && (q.size() > 0);
        if (fl[g]) q.delete();
        else begin
          if (po) void'(q.pop_front());
          if (pu) q.push_back(id[g]);
        end
        blk = 1'b0;
      end
      msz[g] = q.size();
    end

    always @(negedge clk) begin
      chk($sformatf("g%0d count", g),       32'(cnt), 32'(q.size()));
      chk($sformatf("g%0d in_ready", g),    32'(ir),  32'(!blk && q.size() < DP));
      chk($sformatf("g%0d out_valid", g),   32'(ov),  32'(q.size() > 0));
      chk($sformatf("g%0d almost_full", g), 32'(af),  32'(q.size() >= DP-1));
      chk($sformatf("g%0d out_data", g),    32'(od),  (q.size() > 0) ? 32'(q[0]) : 32'h0);
    end
  end

  task automatic directed();
    rst[0] = 1; fl[0] = 0; iv[0] = 0; ordy[0] = 0; id[0] = 0;
    repeat (2) step();
    chk("reset count", 32'(g_f[0].cnt), 0);
    chk("reset out_valid", 32'(g_f[0].ov), 0);
    chk("reset in_ready", 32'(g_f[0].ir), 0);
    chk("reset out_data", 32'(g_f[0].od), 0);
    rst[0] = 0;
    step();
    chk("in_ready after release", 32'(g_f[0].ir), 1);

    // fill with consumer stalled; fifth word must be refused
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1; id[0] = 8'hA0 + 8'(i);
      step();
      chk("fill count", 32'(g_f[0].cnt), (i < 4) ? 32'(i+1) : 32'd4);
      chk("fill almost_full", 32'(g_f[0].af), 32'(i >= 2));
      chk("fill in_ready", 32'(g_f[0].ir), 32'(i < 3));
    end
    chk("model size after fill", 32'(msz[0]), 4);
    iv[0] = 0; ordy[0] = 1;
    for (int i = 0; i < 4; i++) begin
      chk("drain data", 32'(g_f[0].od), 32'(8'hA0 + 8'(i)));
      step();
    end
    chk("drained count", 32'(g_f[0].cnt), 0);
    chk("drained out_data", 32'(g_f[0].od), 0);

    // streaming across several pointer wraps
    for (int k = 0; k < 20; k++) begin
      iv[0] = 1; id[0] = 8'h10 + 8'(k);
      step();
      chk("stream count", 32'(g_f[0].cnt), 1);
      chk("stream data", 32'(g_f[0].od), 32'(8'h10 + 8'(k)));
    end
    iv[0] = 0;
    step();
    chk("stream end count", 32'(g_f[0].cnt), 0);

    // full with simultaneous push attempt and pop
    ordy[0] = 0;
    for (int i = 0; i < 4; i++) begin
      iv[0] = 1; id[0] = 8'hC0 + 8'(i);
      step();
    end
    chk("full count", 32'(g_f[0].cnt), 4);
    iv[0] = 1; id[0] = 8'hCC; ordy[0] = 1;
    chk("full in_ready during pop", 32'(g_f[0].ir), 0);
    step();
    iv[0] = 0;
    chk("full pop count", 32'(g_f[0].cnt), 3);
    chk("full pop in_ready", 32'(g_f[0].ir), 1);
    chk("full pop data", 32'(g_f[0].od), 32'hC1);
    repeat (3) step();
    chk("full drain count", 32'(g_f[0].cnt), 0);

    // flush discards stored words and the push/pop of its own cycle
    ordy[0] = 0;
    for (int i = 0; i < 3; i++) begin
      iv[0] = 1; id[0] = 8'hD0 + 8'(i);
      step();
    end
    chk("pre-flush count", 32'(g_f[0].cnt), 3);
    fl[0] = 1; iv[0] = 1; id[0] = 8'hDD; ordy[0] = 1;
    step();
    fl[0] = 0; iv[0] = 0; ordy[0] = 0;
    chk("flush count", 32'(g_f[0].cnt), 0);
    chk("flush out_valid", 32'(g_f[0].ov), 0);
    chk("flush in_ready", 32'(g_f[0].ir), 1);
    chk("flush out_data", 32'(g_f[0].od), 0);
    iv[0] = 1; id[0] = 8'hE0;
    step();
    iv[0] = 0;
    chk("post-flush data", 32'(g_f[0].od), 32'hE0);
    ordy[0] = 1;
    step();
    ordy[0] = 0;
    chk("post-flush drain", 32'(g_f[0].cnt), 0);

    // asynchronous reset pulse between edges
    for (int i = 0; i < 2; i++) begin
      iv[0] = 1; id[0] = 8'hF0 + 8'(i);
      step();
    end
    iv[0] = 0;
    chk("pre-reset count", 32'(g_f[0].cnt), 2);
    #1 rst[0] = 1;
    #1;
    chk("async out_valid", 32'(g_f[0].ov), 0);
    chk("async count", 32'(g_f[0].cnt), 0);
    chk("async in_ready", 32'(g_f[0].ir), 0);
    chk("async out_data", 32'(g_f[0].od), 0);
    rst[0] = 0;
    step();
    chk("async release in_ready", 32'(g_f[0].ir), 1);
    chk("async release count", 32'(g_f[0].cnt), 0);
    repeat (2) step();
  endtask

  task automatic random_run();
    rst[1] = 1; fl[1] = 0; iv[1] = 0; ordy[1] = 0; id[1] = 0;
    repeat (3) step();
    rst[1] = 0;
    for (int i = 0; i < 10000; i++) begin
      iv[1]   = 1'($urandom_range(0, 1));
      ordy[1] = 1'($urandom_range(0, 1));
      id[1]   = 8'($urandom);
      fl[1]   = ($urandom_range(0, 199) == 0);
      step();
    end
    fl[1] = 0; iv[1] = 0; ordy[1] = 1;
    repeat (10) step();
    chk("random final count", 32'(g_f[1].cnt), 0);
  endtask

  initial begin
    fork
      directed();
      random_run();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
